// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares one synchronous single-port SRAM between the
// CPU load/store port and a debug/DMA port. Each access runs through a fixed
// IDLE -> ISSUE -> RESP sequence. The CPU is stalled until its access
// completes, and debug reads return data with a registered completion pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | arbitrate, latch winner's request and owner
// ISSUE | drive the latched request onto the memory port (mem_en=1)
// RESP  | memory data valid; complete the CPU access or capture debug data
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int DBG_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_valid,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ready,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int            WW       = $clog2(DBG_MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(DBG_MAX_WAIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    logic [1:0]    r_state;
    logic          r_owner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [WW-1:0] r_wait_cnt;
    logic          r_dbg_rvalid;
    logic [DW-1:0] r_dbg_rdata;

    logic w_idle;
    logic w_issue;
    logic w_resp_cpu;
    logic w_resp_dbg;
    logic w_dbg_win;
    logic w_grant;
    logic w_dbg_ready;

    // Arbitration: CPU wins ties until a waiting debug request has been
    // outranked long enough; ready is suppressed while reset is asserted.
    always_comb begin
        w_idle      = (r_state == S_IDLE);
        w_issue     = (r_state == S_ISSUE);
        w_resp_cpu  = (r_state == S_RESP) && (r_owner == OWN_CPU);
        w_resp_dbg  = (r_state == S_RESP) && (r_owner == OWN_DBG);
        w_dbg_win   = dbg_valid && (!cpu_req || (r_wait_cnt >= WAIT_MAX));
        w_grant     = w_idle && (cpu_req || dbg_valid);
        w_dbg_ready = reset && w_idle && w_dbg_win;
    end

    // Access sequencer: one grant, one memory cycle, one response cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  r_state <= w_grant ? S_ISSUE : S_IDLE;
                S_ISSUE: r_state <= S_RESP;
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Latch the winning request so later requester changes cannot disturb it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner <= OWN_CPU;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_owner <= w_dbg_win ? OWN_DBG : OWN_CPU;
            r_we    <= w_dbg_win ? dbg_we    : cpu_we;
            r_addr  <= w_dbg_win ? dbg_addr  : cpu_addr;
            r_wdata <= w_dbg_win ? dbg_wdata : cpu_wdata;
        end
    end

    // Starvation counter for a debug request that keeps losing to the CPU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (!dbg_valid || w_dbg_ready) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != WAIT_MAX) begin
            r_wait_cnt <= r_wait_cnt + WW'(1);
        end
    end

    // Debug completion: pulse one cycle after RESP, hold read data until the next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dbg_rvalid <= 1'b0;
            r_dbg_rdata  <= '0;
        end else begin
            r_dbg_rvalid <= w_resp_dbg;
            if (w_resp_dbg && !r_we) begin
                r_dbg_rdata <= mem_rdata;
            end
        end
    end

    // Output decode; memory port is quiet outside ISSUE so reset drops mem_en at once.
    always_comb begin
        mem_en     = w_issue;
        mem_we     = w_issue && r_we;
        mem_addr   = w_issue ? r_addr  : '0;
        mem_wdata  = w_issue ? r_wdata : '0;
        cpu_stall  = cpu_req && !w_resp_cpu;
        cpu_rdata  = (w_resp_cpu && !r_we) ? mem_rdata : '0;
        dbg_ready  = w_dbg_ready;
        dbg_rvalid = r_dbg_rvalid;
        dbg_rdata  = r_dbg_rdata;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level reference model and a shadow memory.
module tb_dmem_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dbg_valid, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_ready, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    bit [31:0] sram    [64];
    bit [31:0] ref_mem [64];

    dmem_arbiter #(.AW(32), .DW(32), .DBG_MAX_WAIT(MAXW)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .dbg_valid  (dbg_valid),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ready  (dbg_ready),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port SRAM, read data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr[7:2]] <= mem_wdata;
            mem_rdata <= sram[mem_addr[7:2]];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_valid = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        for (int i = 0; i < 8; i++) begin
            cpu_req   = 1'($urandom_range(0, 1));
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = $urandom();
            cpu_wdata = $urandom();
            dbg_valid = 1'($urandom_range(0, 1));
            dbg_we    = 1'($urandom_range(0, 1));
            dbg_addr  = $urandom();
            dbg_wdata = $urandom();
            @(negedge clk);
            checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en i=%0d got=%b exp=0", i, mem_en); end
            checks++; if (dbg_ready !== 1'b0) begin errors++; $display("FAIL rst_dbg_ready i=%0d got=%b exp=0", i, dbg_ready); end
            checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rst_dbg_rvalid i=%0d got=%b exp=0", i, dbg_rvalid); end
            checks++; if (cpu_stall !== cpu_req) begin errors++; $display("FAIL rst_cpu_stall i=%0d got=%b exp=%b", i, cpu_stall, cpu_req); end
            checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_bus i=%0d got addr=%h wdata=%h we=%b exp=0", i, mem_addr, mem_wdata, mem_we); end
            checks++; if (cpu_rdata !== 32'd0 || dbg_rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata i=%0d got cpu=%h dbg=%h exp=0", i, cpu_rdata, dbg_rdata); end
            next_cycle();
        end
        idle_inputs();
        rst_n = 1;
        next_cycle();
    endtask

    task automatic test_cpu_store();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'd84; cpu_wdata = 32'd7;
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b1 || mem_en !== 1'b0) begin errors++; $display("FAIL st_c0 got stall=%b mem_en=%b exp stall=1 mem_en=0", cpu_stall, mem_en); end
        next_cycle();
        @(negedge clk);
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd84 || mem_wdata !== 32'd7) begin errors++; $display("FAIL st_c1_mem got en=%b we=%b addr=%0d wdata=%0d exp 1 1 84 7", mem_en, mem_we, mem_addr, mem_wdata); end
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL st_c1_stall got=%b exp=1", cpu_stall); end
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0 || mem_en !== 1'b0 || cpu_rdata !== 32'd0) begin errors++; $display("FAIL st_c2 got stall=%b mem_en=%b rdata=%h exp 0 0 0", cpu_stall, mem_en, cpu_rdata); end
        ref_mem[21] = 32'd7;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_dbg_read();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'd80; cpu_wdata = 32'h1234;
        next_cycle();
        next_cycle();
        next_cycle();
        ref_mem[20] = 32'h1234;
        idle_inputs();
        dbg_valid = 1; dbg_we = 0; dbg_addr = 32'd80;
        @(negedge clk);
        checks++; if (dbg_ready !== 1'b1) begin errors++; $display("FAIL dr_c0_ready got=%b exp=1", dbg_ready); end
        next_cycle();
        dbg_valid = 0;
        @(negedge clk);
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd80) begin errors++; $display("FAIL dr_c1_mem got en=%b we=%b addr=%0d exp 1 0 80", mem_en, mem_we, mem_addr); end
        checks++; if (dbg_ready !== 1'b0) begin errors++; $display("FAIL dr_c1_ready got=%b exp=0", dbg_ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL dr_c2_rvalid got=%b exp=0", dbg_rvalid); end
        next_cycle();
        @(negedge clk);
        checks++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h1234) begin errors++; $display("FAIL dr_c3 got rvalid=%b rdata=%h exp 1 1234", dbg_rvalid, dbg_rdata); end
        next_cycle();
        @(negedge clk);
        checks++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h1234) begin errors++; $display("FAIL dr_c4 got rvalid=%b rdata=%h exp 0 1234", dbg_rvalid, dbg_rdata); end
        next_cycle();
    endtask

    task automatic test_arbitration();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'd84; cpu_wdata = 32'd0;
        dbg_valid = 1; dbg_we = 1; dbg_addr = 32'd88; dbg_wdata = 32'h55;
        for (int c = 0; c < 12; c++) begin
            if (c == 7) dbg_valid = 0;
            @(negedge clk);
            if (c == 0 || c == 3 || c == 6 || c == 9) begin
                checks++;
                if (dbg_ready !== (c == 6)) begin errors++; $display("FAIL arb_ready c=%0d got=%b exp=%b", c, dbg_ready, (c == 6)); end
            end
            if (c == 1 || c == 4 || c == 10) begin
                checks++;
                if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd84) begin errors++; $display("FAIL arb_cpu_mem c=%0d got en=%b we=%b addr=%0d exp 1 0 84", c, mem_en, mem_we, mem_addr); end
            end
            if (c == 7) begin
                checks++;
                if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd88 || mem_wdata !== 32'h55) begin errors++; $display("FAIL arb_dbg_mem got en=%b we=%b addr=%0d wdata=%h exp 1 1 88 55", mem_en, mem_we, mem_addr, mem_wdata); end
            end
            checks++;
            if (cpu_stall !== !(c == 2 || c == 5 || c == 11)) begin errors++; $display("FAIL arb_stall c=%0d got=%b exp=%b", c, cpu_stall, !(c == 2 || c == 5 || c == 11)); end
            if (c == 2 || c == 5 || c == 11) begin
                checks++;
                if (cpu_rdata !== 32'd7) begin errors++; $display("FAIL arb_cpu_rdata c=%0d got=%h exp=7", c, cpu_rdata); end
            end
            checks++;
            if (dbg_rvalid !== (c == 9)) begin errors++; $display("FAIL arb_rvalid c=%0d got=%b exp=%b", c, dbg_rvalid, (c == 9)); end
            if (c == 9) begin
                checks++;
                if (dbg_rdata !== 32'h1234) begin errors++; $display("FAIL arb_dbg_rdata got=%h exp=1234", dbg_rdata); end
            end
            next_cycle();
        end
        ref_mem[22] = 32'h55;
        idle_inputs();
    endtask

    task automatic test_random();
        int          m_age;
        int          m_wait;
        logic        m_dbg, m_we, m_rvalid, prev_stall;
        logic [31:0] m_addr, m_wdata, m_dbg_rdata;
        logic        dwin, e_ready, e_stall, e_men, e_mwe;
        logic [31:0] e_maddr, e_mwdata, e_crd;

        idle_inputs();
        rst_n = 0;
        next_cycle();
        rst_n = 1;
        m_age = -1; m_wait = 0; m_rvalid = 0; m_dbg_rdata = 0; prev_stall = 0;
        m_dbg = 0; m_we = 0; m_addr = 0; m_wdata = 0;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cpu_req && prev_stall) begin
                if ($urandom_range(0, 19) == 0) cpu_req = 0;
            end else begin
                cpu_req   = ($urandom_range(0, 1) == 1);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 32'($urandom_range(0, 15)) << 2;
                cpu_wdata = $urandom();
            end
            dbg_valid = ($urandom_range(0, 9) < 4);
            dbg_we    = 1'($urandom_range(0, 1));
            dbg_addr  = 32'($urandom_range(0, 15)) << 2;
            dbg_wdata = $urandom();

            @(negedge clk);
            dwin     = (m_age < 0) && dbg_valid && (!cpu_req || m_wait >= MAXW);
            e_ready  = dwin;
            e_men    = (m_age == 1);
            e_mwe    = e_men && m_we;
            e_maddr  = e_men ? m_addr  : 32'd0;
            e_mwdata = e_men ? m_wdata : 32'd0;
            e_stall  = cpu_req && !(m_age == 2 && !m_dbg);
            e_crd    = (m_age == 2 && !m_dbg && !m_we) ? 32'(ref_mem[m_addr[7:2]]) : 32'd0;

            checks++; if (dbg_ready !== e_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, dbg_ready, e_ready); end
            checks++; if (cpu_stall !== e_stall) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, cpu_stall, e_stall); end
            checks++; if (mem_en !== e_men || mem_we !== e_mwe || mem_addr !== e_maddr || mem_wdata !== e_mwdata) begin errors++; $display("FAIL rnd_mem cyc=%0d got en=%b we=%b addr=%h wdata=%h exp en=%b we=%b addr=%h wdata=%h", cyc, mem_en, mem_we, mem_addr, mem_wdata, e_men, e_mwe, e_maddr, e_mwdata); end
            checks++; if (cpu_rdata !== e_crd) begin errors++; $display("FAIL rnd_cpu_rdata cyc=%0d got=%h exp=%h", cyc, cpu_rdata, e_crd); end
            checks++; if (dbg_rvalid !== m_rvalid || dbg_rdata !== m_dbg_rdata) begin errors++; $display("FAIL rnd_dbg_resp cyc=%0d got rvalid=%b rdata=%h exp rvalid=%b rdata=%h", cyc, dbg_rvalid, dbg_rdata, m_rvalid, m_dbg_rdata); end

            m_rvalid = (m_age == 2) && m_dbg;
            if (m_age == 2 && m_dbg && !m_we) m_dbg_rdata = ref_mem[m_addr[7:2]];
            if (m_age == 1 && m_we) ref_mem[m_addr[7:2]] = m_wdata;
            if (!dbg_valid || e_ready) m_wait = 0;
            else if (m_wait < MAXW) m_wait++;
            if (m_age == 2) begin
                m_age = -1;
            end else if (m_age == 1) begin
                m_age = 2;
            end else if (cpu_req || dbg_valid) begin
                m_age   = 1;
                m_dbg   = dwin;
                m_we    = dwin ? dbg_we    : cpu_we;
                m_addr  = dwin ? dbg_addr  : cpu_addr;
                m_wdata = dwin ? dbg_wdata : cpu_wdata;
            end
            prev_stall = e_stall;
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_access();
        idle_inputs();
        repeat (4) next_cycle();
        dbg_valid = 1; dbg_we = 1; dbg_addr = 32'd92; dbg_wdata = 32'hABCD;
        @(negedge clk);
        checks++; if (dbg_ready !== 1'b1) begin errors++; $display("FAIL rm_c0_ready got=%b exp=1", dbg_ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rm_c1_mem_en got=%b exp=1", mem_en); end
        #2;
        rst_n = 0;
        #1;
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0) begin errors++; $display("FAIL rm_async_drop got en=%b we=%b addr=%h exp 0 0 0", mem_en, mem_we, mem_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (dbg_rvalid !== 1'b0 || dbg_ready !== 1'b0) begin errors++; $display("FAIL rm_c2_in_reset got rvalid=%b ready=%b exp 0 0", dbg_rvalid, dbg_ready); end
        next_cycle();
        rst_n = 1;
        @(negedge clk);
        checks++; if (dbg_ready !== 1'b1 || dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rm_c3_regrant got ready=%b rvalid=%b exp 1 0", dbg_ready, dbg_rvalid); end
        next_cycle();
        dbg_valid = 0;
        @(negedge clk);
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd92 || mem_wdata !== 32'hABCD) begin errors++; $display("FAIL rm_c4_mem got en=%b we=%b addr=%0d wdata=%h exp 1 1 92 abcd", mem_en, mem_we, mem_addr, mem_wdata); end
        next_cycle();
        @(negedge clk);
        checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rm_c5_rvalid got=%b exp=0", dbg_rvalid); end
        next_cycle();
        @(negedge clk);
        checks++; if (dbg_rvalid !== 1'b1) begin errors++; $display("FAIL rm_c6_rvalid got=%b exp=1", dbg_rvalid); end
        next_cycle();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        next_cycle();
        test_reset();
        test_cpu_store();
        test_dbg_read();
        test_arbitration();
        test_random();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
